// File: rtl/vga_pkg.sv
// Shared VGA constants for the 1280x1024 mode and the lock FSM encoding.
// The timing generator and the receive-side detector both import this package.
package vga_pkg;

    localparam int MODE_H_SYNC  = 112;
    localparam int MODE_H_BACK  = 248;
    localparam int MODE_H_DISP  = 1280;
    localparam int MODE_H_FRONT = 48;
    localparam int MODE_H_TOTAL = MODE_H_SYNC + MODE_H_BACK + MODE_H_DISP + MODE_H_FRONT;

    localparam int MODE_V_SYNC  = 3;
    localparam int MODE_V_BACK  = 38;
    localparam int MODE_V_DISP  = 1024;
    localparam int MODE_V_FRONT = 1;
    localparam int MODE_V_TOTAL = MODE_V_SYNC + MODE_V_BACK + MODE_V_DISP + MODE_V_FRONT;

    localparam int DEF_HW          = 12;
    localparam int DEF_VW          = 11;
    localparam int DEF_H_TOL       = 2;
    localparam int DEF_LOCK_FRAMES = 2;

    typedef logic [1:0] fsm_state_t;
    localparam fsm_state_t ST_SEARCH  = 2'd0;
    localparam fsm_state_t ST_MEASURE = 2'd1;
    localparam fsm_state_t ST_LOCKED  = 2'd2;

endpackage

// File: rtl/sync_edge_det.sv
// Two-flop synchronizer plus edge register for one sync input.
// Leading/trailing pulses are relative to the active level chosen by pol.
module sync_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic sync_in,
    input  logic pol,
    output logic level,
    output logic lead,
    output logic trail
);

    logic meta_q, meta_d;
    logic sync_q, sync_d;
    logic prev_q, prev_d;
    logic rise, fall;

    always_comb begin
        meta_d = sync_in;
        sync_d = meta_q;
        prev_d = sync_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            prev_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    always_comb begin
        rise  = sync_q & ~prev_q;
        fall  = ~sync_q & prev_q;
        lead  = pol ? rise : fall;
        trail = pol ? fall : rise;
        level = sync_q;
    end

endmodule

// File: rtl/vga_timing_detect.sv
// Measures incoming VGA sync geometry and polarity, locks after repeated identical
// frames, and regenerates disp_enable and pixel coordinates once locked.
module vga_timing_detect
    import vga_pkg::*;
#(
    parameter int H_BACK      = MODE_H_BACK,
    parameter int H_DISP      = MODE_H_DISP,
    parameter int V_BACK      = MODE_V_BACK,
    parameter int V_DISP      = MODE_V_DISP,
    parameter int H_TOL       = DEF_H_TOL,
    parameter int LOCK_FRAMES = DEF_LOCK_FRAMES,
    parameter int HW          = DEF_HW,
    parameter int VW          = DEF_VW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          hsync_in,
    input  logic          vsync_in,
    output logic [HW-1:0] h_total,
    output logic [HW-1:0] h_sync_w,
    output logic [VW-1:0] v_total,
    output logic [VW-1:0] v_sync_w,
    output logic          hs_pol,
    output logic          vs_pol,
    output logic          locked,
    output logic          disp_enable,
    output logic [HW-1:0] x_pix,
    output logic [VW-1:0] y_pix,
    output logic          frame_start
);

    localparam int MW = $clog2(LOCK_FRAMES + 1);
    localparam logic [MW-1:0] MATCH_LOCK = MW'(LOCK_FRAMES - 1);
    localparam logic [HW:0]   H_OFF = (HW + 1)'(H_BACK);
    localparam logic [HW:0]   H_LEN = (HW + 1)'(H_DISP);
    localparam logic [VW:0]   V_OFF = (VW + 1)'(V_BACK);
    localparam logic [VW:0]   V_LEN = (VW + 1)'(V_DISP);

    logic hs_level, hs_lead, hs_trail;
    logic vs_level, vs_lead, vs_trail;

    logic [HW-1:0] h_cnt_q, h_cnt_d, hs_high_q, hs_high_d;
    logic [HW-1:0] h_total_q, h_total_d, h_sync_w_q, h_sync_w_d, ref_h_q, ref_h_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d, vs_high_q, vs_high_d;
    logic [VW-1:0] v_total_q, v_total_d, v_sync_w_q, v_sync_w_d, ref_v_q, ref_v_d;
    logic          hs_pol_q, hs_pol_d, vs_pol_q, vs_pol_d;
    logic [MW-1:0] match_cnt_q, match_cnt_d, match_inc;
    fsm_state_t    state_q, state_d;
    logic          disp_enable_q, disp_enable_d, frame_start_q, frame_start_d;
    logic [HW-1:0] x_pix_q, x_pix_d, h_diff;
    logic [VW-1:0] y_pix_q, y_pix_d;
    logic [HW:0]   h_start, h_end, h_cnt_ext;
    logic [VW:0]   v_start, v_end, v_cnt_ext;
    logic          h_err, v_err, h_timeout, v_timeout, h_act, v_act;

    sync_edge_det u_hs (
        .clk(clk), .rst_n(rst_n), .sync_in(hsync_in), .pol(hs_pol_q),
        .level(hs_level), .lead(hs_lead), .trail(hs_trail)
    );

    sync_edge_det u_vs (
        .clk(clk), .rst_n(rst_n), .sync_in(vsync_in), .pol(vs_pol_q),
        .level(vs_level), .lead(vs_lead), .trail(vs_trail)
    );

    // A period between two consecutive edges of the same kind is a full line even
    // while the polarity guess is wrong, so the high-count vote converges by itself.
    always_comb begin
        h_cnt_d    = (&h_cnt_q) ? h_cnt_q : h_cnt_q + 1'b1;
        hs_high_d  = hs_high_q + HW'(hs_level & ~(&hs_high_q));
        h_total_d  = h_total_q;
        h_sync_w_d = h_sync_w_q;
        hs_pol_d   = hs_pol_q;
        if (hs_lead) begin
            h_cnt_d   = '0;
            h_total_d = h_cnt_q + 1'b1;
            hs_pol_d  = hs_high_q < (h_total_d >> 1);
            hs_high_d = HW'(hs_level);
        end
        if (hs_trail) begin
            h_sync_w_d = h_cnt_q + 1'b1;
        end
    end

    // The line count is advanced before the vsync clear so a coincident hsync
    // edge is included in v_total.
    always_comb begin
        v_cnt_d    = v_cnt_q;
        vs_high_d  = vs_high_q;
        v_total_d  = v_total_q;
        v_sync_w_d = v_sync_w_q;
        vs_pol_d   = vs_pol_q;
        if (hs_lead) begin
            if (!(&v_cnt_q)) begin
                v_cnt_d = v_cnt_q + 1'b1;
            end
            vs_high_d = vs_high_q + VW'(vs_level & ~(&vs_high_q));
        end
        if (vs_trail) begin
            v_sync_w_d = v_cnt_d;
        end
        if (vs_lead) begin
            v_total_d = v_cnt_d;
            vs_pol_d  = vs_high_q < (v_total_d >> 1);
            vs_high_d = VW'(vs_level);
            v_cnt_d   = '0;
        end
    end

    always_comb begin
        h_diff    = (h_total_d >= ref_h_q) ? h_total_d - ref_h_q : ref_h_q - h_total_d;
        h_err     = hs_lead && (h_diff > HW'(H_TOL));
        v_err     = vs_lead && (v_total_d != ref_v_q);
        h_timeout = &h_cnt_q;
        v_timeout = {1'b0, v_cnt_q} >= {ref_v_q, 1'b0};
        match_inc = match_cnt_q + 1'b1;

        state_d     = state_q;
        ref_h_d     = ref_h_q;
        ref_v_d     = ref_v_q;
        match_cnt_d = match_cnt_q;
        case (state_q)
            ST_SEARCH: begin
                if (vs_lead) begin
                    state_d     = ST_MEASURE;
                    ref_h_d     = h_total_d;
                    ref_v_d     = v_total_d;
                    match_cnt_d = '0;
                end
            end
            ST_MEASURE: begin
                if (vs_lead) begin
                    if (h_total_d == ref_h_q && v_total_d == ref_v_q) begin
                        match_cnt_d = match_inc;
                        if (match_inc >= MATCH_LOCK) begin
                            state_d = ST_LOCKED;
                        end
                    end else begin
                        ref_h_d     = h_total_d;
                        ref_v_d     = v_total_d;
                        match_cnt_d = '0;
                    end
                end
            end
            ST_LOCKED: begin
                if (h_err || v_err || h_timeout || v_timeout) begin
                    state_d = ST_SEARCH;
                end
            end
            default: state_d = ST_SEARCH;
        endcase
    end

    always_comb begin
        h_cnt_ext     = {1'b0, h_cnt_q};
        v_cnt_ext     = {1'b0, v_cnt_q};
        h_start       = {1'b0, h_sync_w_q} + H_OFF;
        h_end         = h_start + H_LEN;
        v_start       = {1'b0, v_sync_w_q} + V_OFF;
        v_end         = v_start + V_LEN;
        h_act         = (h_cnt_ext >= h_start) && (h_cnt_ext < h_end);
        v_act         = (v_cnt_ext >= v_start) && (v_cnt_ext < v_end);
        disp_enable_d = (state_q == ST_LOCKED) && h_act && v_act;
        x_pix_d       = disp_enable_d ? HW'(h_cnt_ext - h_start) : '0;
        y_pix_d       = disp_enable_d ? VW'(v_cnt_ext - v_start) : '0;
        frame_start_d = vs_lead;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_cnt_q       <= '0;
            hs_high_q     <= '0;
            h_total_q     <= '0;
            h_sync_w_q    <= '0;
            hs_pol_q      <= 1'b0;
            v_cnt_q       <= '0;
            vs_high_q     <= '0;
            v_total_q     <= '0;
            v_sync_w_q    <= '0;
            vs_pol_q      <= 1'b0;
            state_q       <= ST_SEARCH;
            ref_h_q       <= '0;
            ref_v_q       <= '0;
            match_cnt_q   <= '0;
            disp_enable_q <= 1'b0;
            x_pix_q       <= '0;
            y_pix_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            h_cnt_q       <= h_cnt_d;
            hs_high_q     <= hs_high_d;
            h_total_q     <= h_total_d;
            h_sync_w_q    <= h_sync_w_d;
            hs_pol_q      <= hs_pol_d;
            v_cnt_q       <= v_cnt_d;
            vs_high_q     <= vs_high_d;
            v_total_q     <= v_total_d;
            v_sync_w_q    <= v_sync_w_d;
            vs_pol_q      <= vs_pol_d;
            state_q       <= state_d;
            ref_h_q       <= ref_h_d;
            ref_v_q       <= ref_v_d;
            match_cnt_q   <= match_cnt_d;
            disp_enable_q <= disp_enable_d;
            x_pix_q       <= x_pix_d;
            y_pix_q       <= y_pix_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign h_total     = h_total_q;
    assign h_sync_w    = h_sync_w_q;
    assign v_total     = v_total_q;
    assign v_sync_w    = v_sync_w_q;
    assign hs_pol      = hs_pol_q;
    assign vs_pol      = vs_pol_q;
    assign locked      = (state_q == ST_LOCKED);
    assign disp_enable = disp_enable_q;
    assign x_pix       = x_pix_q;
    assign y_pix       = y_pix_q;
    assign frame_start = frame_start_q;

endmodule
